// File: rtl/stream_buffer.sv
// Registered-output FIFO stream buffer with valid/ready on both sides.
// Optional statistics ports (peak occupancy, stall cycles) are enabled by defining STREAM_BUFFER_STATS_EN.
module stream_buffer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [WIDTH-1:0]           o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
`ifdef STREAM_BUFFER_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_peak_count,
  output logic [31:0]                o_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_n;
  logic             push;
  logic             pop;

  // Handshake: a word moves on a rising edge when valid and ready are both high;
  // ready never depends on the same side's valid, and out-side ready does not feed in_ready.
  assign o_in_ready    = !i_reset && (count < FULL_LEVEL);
  assign o_out_valid   = (count != '0);
  assign o_out_data    = head;
  assign o_count       = count;
  assign o_almost_full = (count >= AFULL_C);

  assign push        = i_in_valid && o_in_ready;
  assign pop         = o_out_valid && i_out_ready;
  assign rd_next_ptr = rd_ptr + AW'(1);

  always_comb begin
    count_n = count;
    head_n  = head;
    if (i_flush) begin
      count_n = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
      // The head register is refilled from storage, or straight from the input
      // when the incoming word becomes the new head.
      if (pop && (count != CW'(1))) begin
        head_n = mem[rd_next_ptr];
      end else if (push && ((count == '0) || pop)) begin
        head_n = i_in_data;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (i_flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next_ptr;
      count <= count_n;
      head  <= head_n;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push && !i_flush) mem[wr_ptr] <= i_in_data;
  end

`ifdef STREAM_BUFFER_STATS_EN
  logic [CW-1:0] peak;
  logic [31:0]   stall;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      peak  <= '0;
      stall <= '0;
    end else if (i_flush) begin
      peak  <= '0;
      stall <= '0;
    end else begin
      if (count_n > peak) peak <= count_n;
      if (i_in_valid && !o_in_ready && (stall != '1)) stall <= stall + 32'd1;
    end
  end

  assign o_peak_count   = peak;
  assign o_stall_cycles = stall;
`endif

endmodule
